pic16f84_hex_dump: RTL and testbench

- Reads a range of program-memory words and emits them as an Intel HEX text stream, one ASCII byte per handshake.
- It is the writer-side counterpart of the HEX-loading program ROM: its output, saved to a file, can be reloaded into program memory unchanged.
- It sits between the program memory's synchronous read port and a byte-wide transmit sink, such as a UART TX or a simulation file sink.

---
 rtl/pic16f84_pkg.sv | 36 +++
 rtl/pic16f84_hex_dump_if.sv | 30 +++
 rtl/pic16f84_hex_byte_tx.sv | 53 +++++
 rtl/pic16f84_hex_dump.sv | 207 ++++++++++++++++++++
 tb/tb_pic16f84_hex_dump.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic16f84_pkg.sv
// Shared definitions for the Intel HEX dumper.
// Contents: FSM state enum, ASCII and record-type constants, the payload
// struct handed to the byte transmitter, and a nibble-to-ASCII helper.
package pic16f84_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_CR,
    ST_LF,
    ST_EOFREC,
    ST_DONE
  } state_e;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [7:0] REC_DATA = 8'h00;
  localparam logic [7:0] REC_EOF  = 8'h01;

  // raw=1: send data as one literal character; raw=0: send it as two hex digits
  typedef struct packed {
    logic       raw;
    logic [7:0] data;
  } tx_byte_t;

  // 4-bit value to uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
  endfunction

endpackage

// File: rtl/pic16f84_hex_dump_if.sv
// Memory read port and byte-wide transmit handshake used by the HEX dumper.
// master: the dumper (drives mem_addr, tx_data, tx_valid).
// slave:  program memory plus character sink (drives mem_rdata, tx_ready).
interface pic16f84_hex_dump_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [13:0]       mem_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_addr,
    output tx_data,
    output tx_valid,
    input  mem_rdata,
    input  tx_ready
  );

  modport slave (
    input  mem_addr,
    input  tx_data,
    input  tx_valid,
    output mem_rdata,
    output tx_ready
  );

endinterface

// File: rtl/pic16f84_hex_byte_tx.sv
// Byte-to-character transmitter for the HEX dumper.
// Accepts one byte per in_valid & in_ready_c and sends it either as a single
// literal character or as two uppercase hex digits, high nibble first.
// Ports: clk, rst (sync, active high); in_valid/in_byte/in_ready_c byte
// request side; tx_data/tx_valid/tx_ready character handshake side.
module pic16f84_hex_byte_tx
  import pic16f84_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  tx_byte_t   in_byte,
  output logic       in_ready_c,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  logic       pend;
  logic [3:0] pend_lo;

  // A new byte can be loaded once no low nibble is waiting and the output
  // register is empty or being drained this cycle; keeps characters back to back.
  assign in_ready_c = !pend && (!tx_valid || tx_ready);

  // Output register; tx_data is only rewritten when empty or just accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      pend     <= 1'b0;
      pend_lo  <= 4'h0;
    end else if (in_valid && in_ready_c) begin
      tx_valid <= 1'b1;
      pend_lo  <= in_byte.data[3:0];
      if (in_byte.raw) begin
        tx_data <= in_byte.data;
        pend    <= 1'b0;
      end else begin
        tx_data <= hex_ascii(in_byte.data[7:4]);
        pend    <= 1'b1;
      end
    end else if (tx_valid && tx_ready) begin
      if (pend) begin
        tx_data <= hex_ascii(pend_lo);
        pend    <= 1'b0;
      end else begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pic16f84_hex_dump.sv
// Dumps a range of program-memory words as an Intel HEX character stream.
// Ports: clk, rst (sync, active high); start/start_addr/word_count request;
// busy/done status; bus (master) carries the memory read port and the
// character transmit handshake.
module pic16f84_hex_dump
  import pic16f84_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned MEM_DEPTH     = 1024,
  parameter int unsigned WORDS_PER_REC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  pic16f84_hex_dump_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e           state, state_nxt;
  logic [2:0]       idx;
  logic             hi_phase;
  logic [7:0]       hi_q;
  logic [13:0]      word_q;
  logic [1:0]       rd_pipe;
  logic [CNT_W-1:0] rem;
  logic [6:0]       rec_words;
  logic [7:0]       rec_ll;
  logic [7:0]       csum;

  logic             in_valid_c;
  logic             in_ready_c;
  tx_byte_t         in_byte_c;
  logic             accept_c;
  logic [15:0]      aaaa_c;
  logic [CNT_W-1:0] until_wrap_c;
  logic [CNT_W-1:0] n_c;

  assign accept_c     = in_valid_c && in_ready_c;
  assign aaaa_c       = 16'({bus.mem_addr, 1'b0});
  assign until_wrap_c = CNT_W'(MEM_DEPTH) - CNT_W'(bus.mem_addr);

  // Words in the next record: limited by remaining count, record size and wrap
  always_comb begin
    n_c = rem;
    if (n_c > CNT_W'(WORDS_PER_REC)) n_c = CNT_W'(WORDS_PER_REC);
    if (n_c > until_wrap_c)          n_c = until_wrap_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (word_count == '0) ? ST_EOFREC : ST_FETCH;
      ST_FETCH:  state_nxt = ST_HDR;
      ST_HDR:    if (accept_c && idx == 3'd4) state_nxt = ST_DATA;
      ST_DATA:   if (accept_c && hi_phase && rec_words == 7'd1) state_nxt = ST_CSUM;
      ST_CSUM:   if (accept_c) state_nxt = ST_CR;
      ST_CR:     if (accept_c) state_nxt = ST_LF;
      ST_LF:     if (accept_c) state_nxt = (rem != '0) ? ST_FETCH : ST_EOFREC;
      ST_EOFREC: if (accept_c && idx == 3'd7) state_nxt = ST_DONE;
      ST_DONE:   if (bus.tx_valid && bus.tx_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Byte request to the transmitter for the current field
  always_comb begin
    in_valid_c     = 1'b0;
    in_byte_c.raw  = 1'b0;
    in_byte_c.data = 8'h00;
    case (state)
      ST_HDR: begin
        in_valid_c = 1'b1;
        case (idx)
          3'd0:    begin in_byte_c.raw = 1'b1; in_byte_c.data = ASCII_COLON; end
          3'd1:    in_byte_c.data = rec_ll;
          3'd2:    in_byte_c.data = aaaa_c[15:8];
          3'd3:    in_byte_c.data = aaaa_c[7:0];
          default: in_byte_c.data = REC_DATA;
        endcase
      end
      ST_DATA: begin
        // low byte waits until the fetched word has landed in word_q
        in_valid_c     = hi_phase || (rd_pipe == 2'b00);
        in_byte_c.data = hi_phase ? hi_q : word_q[7:0];
      end
      ST_CSUM: begin
        in_valid_c     = 1'b1;
        in_byte_c.data = 8'h00 - csum;
      end
      ST_CR: begin
        in_valid_c     = 1'b1;
        in_byte_c.raw  = 1'b1;
        in_byte_c.data = ASCII_CR;
      end
      ST_LF: begin
        in_valid_c     = 1'b1;
        in_byte_c.raw  = 1'b1;
        in_byte_c.data = ASCII_LF;
      end
      ST_EOFREC: begin
        in_valid_c = 1'b1;
        case (idx)
          3'd0:    begin in_byte_c.raw = 1'b1; in_byte_c.data = ASCII_COLON; end
          3'd4:    in_byte_c.data = REC_EOF;
          3'd5:    in_byte_c.data = 8'hFF;
          3'd6:    begin in_byte_c.raw = 1'b1; in_byte_c.data = ASCII_CR; end
          3'd7:    begin in_byte_c.raw = 1'b1; in_byte_c.data = ASCII_LF; end
          default: in_byte_c.data = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  // Datapath: addresses, counters, checksum, fetch pipeline, status
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr <= '0;
      idx          <= 3'd0;
      hi_phase     <= 1'b0;
      hi_q         <= 8'h00;
      word_q       <= 14'h0;
      rd_pipe      <= 2'b00;
      rem          <= '0;
      rec_words    <= 7'd0;
      rec_ll       <= 8'h00;
      csum         <= 8'h00;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done    <= 1'b0;
      // address presented in one cycle, data captured at the end of the next
      rd_pipe <= {rd_pipe[0], 1'b0};
      if (rd_pipe[1]) word_q <= bus.mem_rdata;

      if (state != state_nxt) idx <= 3'd0;
      else if (accept_c)      idx <= idx + 3'd1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            bus.mem_addr <= start_addr;
            rem          <= word_count;
            busy         <= 1'b1;
            if (word_count != '0) rd_pipe <= 2'b01;
          end
        end
        ST_FETCH: begin
          rec_words <= 7'(n_c);
          rec_ll    <= {7'(n_c), 1'b0};
        end
        ST_HDR: begin
          if (accept_c) csum <= (idx == 3'd0) ? 8'h00 : csum + in_byte_c.data;
        end
        ST_DATA: begin
          if (accept_c) begin
            csum <= csum + in_byte_c.data;
            if (!hi_phase) begin
              hi_q     <= {2'b00, word_q[13:8]};
              hi_phase <= 1'b1;
              rem      <= rem - CNT_W'(1);
              // prefetch the following word while this one is still being sent
              if (rem > CNT_W'(1)) begin
                bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                rd_pipe      <= 2'b01;
              end
            end else begin
              hi_phase  <= 1'b0;
              rec_words <= rec_words - 7'd1;
            end
          end
        end
        ST_DONE: begin
          if (bus.tx_valid && bus.tx_ready) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pic16f84_hex_byte_tx u_byte_tx (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid_c),
    .in_byte    (in_byte_c),
    .in_ready_c (in_ready_c),
    .tx_data    (bus.tx_data),
    .tx_valid   (bus.tx_valid),
    .tx_ready   (bus.tx_ready)
  );

endmodule

// File: tb/tb_pic16f84_hex_dump.sv
// Testbench for pic16f84_hex_dump: scoreboard of expected characters built
// from a reference model of the Intel HEX format, drained as the DUT sends.
module tb_pic16f84_hex_dump;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int WPR    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic              busy;
  logic              done;

  pic16f84_hex_dump_if #(.ADDR_W(ADDR_W)) bus ();

  pic16f84_hex_dump #(
    .ADDR_W        (ADDR_W),
    .MEM_DEPTH     (DEPTH),
    .WORDS_PER_REC (WPR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [13:0] mem [0:DEPTH-1];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  logic [7:0] sb[$];
  int         addr_q[$];
  int         checks = 0;
  int         errors = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         idle_cnt = 0;
  int         stall_cycles = 0;
  int         last_addr = -1;
  int         msum = 0;
  bit         hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_chr(input logic [7:0] c);
    sb.push_back(c);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
  endtask

  task automatic push_crlf();
    push_chr(8'h0D);
    push_chr(8'h0A);
  endtask

  task automatic push_hex(input int b);
    msum = (msum + b) & 255;
    push_chr(hexc((b >> 4) & 15));
    push_chr(hexc(b & 15));
  endtask

  // Reference Intel HEX writer
  task automatic model_push(input int sa, input int wc);
    int addr, rem, n, w;
    addr = sa;
    rem  = wc;
    while (rem > 0) begin
      n = rem;
      if (n > WPR) n = WPR;
      if (n > DEPTH - addr) n = DEPTH - addr;
      push_chr(8'h3A);
      msum = 0;
      push_hex(2 * n);
      push_hex(((addr * 2) >> 8) & 255);
      push_hex((addr * 2) & 255);
      push_hex(0);
      for (int i = 0; i < n; i++) begin
        w = int'(mem[addr]);
        push_hex(w & 255);
        push_hex(w >> 8);
        addr = (addr + 1) % DEPTH;
        rem--;
      end
      push_hex((256 - msum) & 255);
      push_crlf();
    end
    push_str(":00000001FF");
    push_crlf();
  endtask

  // Character monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", int'(bus.tx_valid), 1);
        check("hold_data", int'(bus.tx_data), int'(prev_data));
        stall_cycles++;
      end
      hold_prev = bus.tx_valid && !bus.tx_ready;
      prev_data = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        acc_cnt++;
        if (sb.size() == 0) check("extra_char", int'(bus.tx_data), -1);
        else                check("char", int'(bus.tx_data), int'(sb.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("done_busy", int'(busy), 0);
        check("done_drained", sb.size(), 0);
      end
      if (busy && !bus.tx_valid) idle_cnt++;
      if (busy && int'(bus.mem_addr) != last_addr) begin
        last_addr = int'(bus.mem_addr);
        addr_q.push_back(last_addr);
      end
    end
  end

  // Run one dump whose expected stream is already on the scoreboard
  task automatic run_dump(input int sa, input int wc, input int stall_at, input bit spur);
    int d0, a0, t;
    bit stalled;
    d0 = done_cnt;
    a0 = acc_cnt;
    idle_cnt = 0;
    stall_cycles = 0;
    addr_q.delete();
    last_addr = -1;
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = ADDR_W'(sa);
    word_count = (ADDR_W + 1)'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    t = 0;
    stalled = 1'b0;
    while (done_cnt == d0 && t < 20000) begin
      if (spur && t == 20) begin
        start = 1'b1;
        start_addr = 10'd100;
        word_count = 11'd2;
      end
      if (spur && t == 21) start = 1'b0;
      if (stall_at >= 0 && !stalled && acc_cnt - a0 >= stall_at) begin
        stalled = 1'b1;
        bus.tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", int'(done_cnt != d0), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("sb_left", sb.size(), 0);
    if (stall_at < 0) check("idle_budget", int'(idle_cnt <= wc + 2), 1);
    else              check("stall_hold", int'(stall_cycles >= 4), 1);
    sb.delete();
  endtask

  initial begin
    int d0, a0, t;
    int exp_a[4];
    exp_a = '{1022, 1023, 0, 1};
    for (int i = 0; i < DEPTH; i++) mem[i] = 14'($urandom);
    mem[0] = 14'h2805;
    bus.tx_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", int'(bus.tx_valid), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    // single word, golden text
    push_str(":020000000528D1");
    push_crlf();
    push_str(":00000001FF");
    push_crlf();
    run_dump(0, 1, -1, 1'b0);

    // two records, with an ignored start while busy
    model_push(3, 9);
    run_dump(3, 9, -1, 1'b1);

    // empty dump
    model_push(0, 0);
    run_dump(0, 0, -1, 1'b0);

    // sink stall in the data field
    model_push(5, 3);
    run_dump(5, 3, 12, 1'b0);

    // address wrap
    model_push(1022, 4);
    run_dump(1022, 4, -1, 1'b0);
    check("addr_n", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check("addr_seq", addr_q[i], exp_a[i]);

    // reset in the middle of a dump
    model_push(200, 20);
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = 10'd200;
    word_count = 11'd20;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (acc_cnt - a0 < 7 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_reach", int'(acc_cnt - a0 >= 7), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", int'(bus.tx_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_nodone", done_cnt - d0, 0);
    check("abort_quiet", int'(bus.tx_valid), 0);

    model_push(40, 10);
    run_dump(40, 10, -1, 1'b0);

    // whole memory from an odd start, crossing the wrap
    model_push(17, DEPTH);
    run_dump(17, DEPTH, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
